cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Transmitting end of the common data bus (CDB). Collects completed results from N_SRC functional
//  units, buffers them per source, and broadcasts one {tag, data} per cycle on o_cdb_* to the
//  register file, the reservation stations and the history file. Round-robin arbitration.
//  Branch resolution drops speculative results on a mispredict and commits them on a correct prediction.
// PARAMETERS
//  BW_PROCESSOR_DATA  32  result data width
//  BW_TAG             3   tag width; tag 0 means "no producer" and is never broadcast
//  N_SRC              4   number of functional-unit result sources
//  DEPTH              2   per-source buffer entries (>=1)
// PORTS
//  clk                           in   1                    clock; all logic on posedge
//  rst                           in   1                    synchronous reset, active-high
//  i_fu_valid                    in   N_SRC                source s presents a result
//  o_fu_ready                    out  N_SRC                source s buffer can accept
//  i_fu_tag_flatten              in   N_SRC*BW_TAG         tag of source s at [s*BW_TAG +: BW_TAG]
//  i_fu_wdata_flatten            in   N_SRC*BW_PROCESSOR_DATA  signed result of source s
//  i_fu_speculation              in   N_SRC                result belongs to an unresolved branch path
//  i_branch_valid                in   1                    branch resolved this cycle
//  i_branch_correct_prediction   in   1                    qualifies i_branch_valid
//  o_cdb_valid                   out  1                    broadcast valid
//  o_cdb_tag                     out  BW_TAG               broadcast tag
//  o_cdb_wdata                   out  BW_PROCESSOR_DATA    signed broadcast data
// BEHAVIOUR
//  - Reset: all buffers empty, all spec bits 0, round-robin pointer = 0.
//    o_cdb_valid=0, o_cdb_tag=0, o_cdb_wdata=0.
//    o_fu_ready=0 while rst=1; all 1 in the first cycle after rst falls.
//  - Reset asserted mid-operation: buffered results and any pending broadcast are discarded.
//  - Handshake: transfer on i_fu_valid[s] && o_fu_ready[s].
//    o_fu_ready[s] = (count[s] < DEPTH); it comes from the registered count, so a same-cycle pop does
//    not raise ready (no pass-through). Tag/data/spec are held by the source until transfer.
//  - Storage: per-source entries {tag, data, spec}, kept in arrival order.
//    A transfer with tag 0 is accepted and discarded.
//  - Arbitration (per cycle):
//    - Candidates are heads of non-empty buffers after this cycle's flush removal.
//      Entries written this cycle are not candidates.
//    - Winner = first candidate at or after rr_ptr, wrapping modulo N_SRC.
//    - Winner's head is popped; rr_ptr <= winner+1 (wraps to 0). No winner: rr_ptr unchanged.
//  - Output register: o_cdb_* <= winner's {1, tag, data}, or {0, 0, 0} if none.
//    Latency: accepted at edge t, earliest o_cdb_valid=1 in cycle t+1. Throughput: 1 result/cycle.
//  - Flush (i_branch_valid && !i_branch_correct_prediction):
//    - Every stored entry with spec=1 is removed; survivors compact toward the head, order preserved.
//    - A same-cycle transfer with i_fu_speculation=1 is accepted and discarded.
//    - The broadcast already in the output register is not cancelled.
//  - Correct prediction (i_branch_valid && i_branch_correct_prediction):
//    all stored spec bits cleared; a same-cycle transfer is stored with spec=0.
//  - Simultaneous push and pop on one source: both occur; count unchanged.
//  - At most one branch event per cycle; there is no nesting of speculation levels.
// TESTING
//  1 Reset: rst=1 for 2 cycles, then 0 -> o_cdb_valid=0 and tag/data=0 during reset;
//    o_fu_ready=4'b1111 one cycle after release.
//  2 Single result: src1 pushes tag=3, data=-5 at edge t -> o_cdb_valid=1, tag=3, data=-5 in cycle
//    t+1 only; valid=0 in t+2.
//  3 Contention: all 4 sources push once in the same cycle (tags 1..4), rr_ptr=0 -> broadcasts on 4
//    consecutive cycles, tags 1,2,3,4; then rr_ptr=0. Repeating with src2,src3 only gives 3 then 4.
//  4 Full: src0 pushes 3 results while src1 continually wins ahead of it -> o_fu_ready[0]=0 after 2
//    accepted, 3rd held until first src0 broadcast; order of src0 tags preserved.
//  5 Flush: src0 holds {tag2 spec=0, tag5 spec=1}; mispredict pulse -> tag5 never broadcast,
//    tag2 broadcast; same-cycle spec push with tag6 never appears.
//  6 Commit: src0 holds tag5 spec=1; correct-prediction pulse, then mispredict pulse 1 cycle later ->
//    tag5 still broadcast.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Bundle of the functional-unit result ports, the branch-resolution inputs and
// the common-data-bus broadcast outputs of the CDB arbiter.
// Valid/ready: a source result moves into the arbiter on a rising clk edge where
// i_fu_valid[s] && o_fu_ready[s]; until then the source holds valid, tag, data
// and speculation stable. The CDB side has no back-pressure: o_cdb_valid marks
// a one-cycle broadcast that every listener must take.
interface cdb_arbiter_if #(
  parameter int BW_PROCESSOR_DATA = 32,
  parameter int BW_TAG            = 3,
  parameter int N_SRC             = 4
);
  logic [N_SRC-1:0]                   i_fu_valid;
  logic [N_SRC-1:0]                   o_fu_ready;
  logic [N_SRC*BW_TAG-1:0]            i_fu_tag_flatten;
  logic [N_SRC*BW_PROCESSOR_DATA-1:0] i_fu_wdata_flatten;
  logic [N_SRC-1:0]                   i_fu_speculation;
  logic                               i_branch_valid;
  logic                               i_branch_correct_prediction;
  logic                               o_cdb_valid;
  logic [BW_TAG-1:0]                  o_cdb_tag;
  logic signed [BW_PROCESSOR_DATA-1:0] o_cdb_wdata;

  // Functional units and branch unit side
  modport master (
    output i_fu_valid, i_fu_tag_flatten, i_fu_wdata_flatten, i_fu_speculation,
    output i_branch_valid, i_branch_correct_prediction,
    input  o_fu_ready, o_cdb_valid, o_cdb_tag, o_cdb_wdata
  );

  // Arbiter side
  modport slave (
    input  i_fu_valid, i_fu_tag_flatten, i_fu_wdata_flatten, i_fu_speculation,
    input  i_branch_valid, i_branch_correct_prediction,
    output o_fu_ready, o_cdb_valid, o_cdb_tag, o_cdb_wdata
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Transmitting end of the common data bus. Each functional unit owns a small
// in-order result buffer; one buffered result per cycle is chosen round-robin
// and broadcast as {tag, data}. A branch mispredict drops speculative entries,
// a correct prediction turns them into ordinary (committed) entries.
module cdb_arbiter #(
  parameter int BW_PROCESSOR_DATA = 32,
  parameter int BW_TAG            = 3,
  parameter int N_SRC             = 4,
  parameter int DEPTH             = 2
) (
  input logic         clk,
  input logic         rst,
  cdb_arbiter_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  // Registered per-source buffers, head at index 0
  logic [BW_TAG-1:0]            q_tag  [N_SRC][DEPTH];
  logic [BW_PROCESSOR_DATA-1:0] q_data [N_SRC][DEPTH];
  logic                         q_spec [N_SRC][DEPTH];
  logic [CW-1:0]                q_cnt  [N_SRC];
  logic [PW-1:0]                rr_ptr;

  // Buffers after this cycle's flush/commit
  logic [BW_TAG-1:0]            f_tag  [N_SRC][DEPTH];
  logic [BW_PROCESSOR_DATA-1:0] f_data [N_SRC][DEPTH];
  logic                         f_spec [N_SRC][DEPTH];
  logic [CW-1:0]                f_cnt  [N_SRC];

  // Buffers after pop and push (next state)
  logic [BW_TAG-1:0]            n_tag  [N_SRC][DEPTH];
  logic [BW_PROCESSOR_DATA-1:0] n_data [N_SRC][DEPTH];
  logic                         n_spec [N_SRC][DEPTH];
  logic [CW-1:0]                n_cnt  [N_SRC];

  logic                         flush;
  logic                         commit;
  logic [N_SRC-1:0]             ready;
  logic                         win_vld;
  logic [PW-1:0]                win_idx;
  logic [BW_TAG-1:0]            win_tag;
  logic [BW_PROCESSOR_DATA-1:0] win_data;

  logic                         cdb_valid_q;
  logic [BW_TAG-1:0]            cdb_tag_q;
  logic [BW_PROCESSOR_DATA-1:0] cdb_data_q;

  assign flush  = bus.i_branch_valid && !bus.i_branch_correct_prediction;
  assign commit = bus.i_branch_valid &&  bus.i_branch_correct_prediction;

  // Ready from the registered count only, so a pop never lets a push through in the same cycle
  always_comb begin
    ready = '0;
    for (int s = 0; s < N_SRC; s++) begin
      ready[s] = !rst && (q_cnt[s] < CW'(DEPTH));
    end
  end

  assign bus.o_fu_ready  = ready;
  assign bus.o_cdb_valid = cdb_valid_q;
  assign bus.o_cdb_tag   = cdb_tag_q;
  assign bus.o_cdb_wdata = cdb_data_q;

  // Flush drops speculative entries and compacts survivors toward the head; commit clears spec bits
  always_comb begin
    for (int s = 0; s < N_SRC; s++) begin
      f_cnt[s] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        f_tag[s][j]  = '0;
        f_data[s][j] = '0;
        f_spec[s][j] = 1'b0;
      end
    end
    for (int s = 0; s < N_SRC; s++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if ((CW'(e) < q_cnt[s]) && !(flush && q_spec[s][e])) begin
          for (int j = 0; j < DEPTH; j++) begin
            if (f_cnt[s] == CW'(j)) begin
              f_tag[s][j]  = q_tag[s][e];
              f_data[s][j] = q_data[s][e];
              f_spec[s][j] = q_spec[s][e] && !commit;
            end
          end
          f_cnt[s] = f_cnt[s] + CW'(1);
        end
      end
    end
  end

  // Round-robin pick: first non-empty (post-flush) buffer at or after rr_ptr
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!win_vld && (f_cnt[(int'(rr_ptr) + i) % N_SRC] != '0)) begin
        win_vld = 1'b1;
        win_idx = PW'((int'(rr_ptr) + i) % N_SRC);
      end
    end
    win_tag  = f_tag[win_idx][0];
    win_data = f_data[win_idx][0];
  end

  // Pop the winner's head, then append this cycle's accepted result behind the survivors
  always_comb begin
    for (int s = 0; s < N_SRC; s++) begin
      n_cnt[s] = f_cnt[s];
      for (int j = 0; j < DEPTH; j++) begin
        n_tag[s][j]  = f_tag[s][j];
        n_data[s][j] = f_data[s][j];
        n_spec[s][j] = f_spec[s][j];
      end
      if (win_vld && (win_idx == PW'(s))) begin
        for (int j = 0; j < DEPTH - 1; j++) begin
          n_tag[s][j]  = f_tag[s][j+1];
          n_data[s][j] = f_data[s][j+1];
          n_spec[s][j] = f_spec[s][j+1];
        end
        n_tag[s][DEPTH-1]  = '0;
        n_data[s][DEPTH-1] = '0;
        n_spec[s][DEPTH-1] = 1'b0;
        n_cnt[s] = f_cnt[s] - CW'(1);
      end
      // Tag 0 and speculative results arriving with a mispredict are accepted but not stored
      if (bus.i_fu_valid[s] && ready[s] &&
          (bus.i_fu_tag_flatten[s*BW_TAG +: BW_TAG] != '0) &&
          !(flush && bus.i_fu_speculation[s])) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (n_cnt[s] == CW'(j)) begin
            n_tag[s][j]  = bus.i_fu_tag_flatten[s*BW_TAG +: BW_TAG];
            n_data[s][j] = bus.i_fu_wdata_flatten[s*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];
            n_spec[s][j] = bus.i_fu_speculation[s] && !commit;
          end
        end
        n_cnt[s] = n_cnt[s] + CW'(1);
      end
    end
  end

  // State update: buffers, round-robin pointer and the broadcast register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < N_SRC; s++) begin
        q_cnt[s] <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          q_tag[s][j]  <= '0;
          q_data[s][j] <= '0;
          q_spec[s][j] <= 1'b0;
        end
      end
      rr_ptr      <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else begin
      q_tag  <= n_tag;
      q_data <= n_data;
      q_spec <= n_spec;
      q_cnt  <= n_cnt;
      if (win_vld) begin
        rr_ptr      <= (win_idx == PW'(N_SRC - 1)) ? '0 : win_idx + PW'(1);
        cdb_valid_q <= 1'b1;
        cdb_tag_q   <= win_tag;
        cdb_data_q  <= win_data;
      end else begin
        cdb_valid_q <= 1'b0;
        cdb_tag_q   <= '0;
        cdb_data_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for the CDB arbiter: reset, latency, round-robin contention,
// back-pressure, mispredict flush, correct-prediction commit, tag-0 drop,
// back-to-back throughput and reset during traffic.
module tb_cdb_arbiter;
  localparam int DW = 32;
  localparam int TW = 3;
  localparam int NS = 4;
  localparam int DP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  cdb_arbiter_if #(.BW_PROCESSOR_DATA(DW), .BW_TAG(TW), .N_SRC(NS)) bus ();

  cdb_arbiter #(.BW_PROCESSOR_DATA(DW), .BW_TAG(TW), .N_SRC(NS), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic v, input logic [TW-1:0] tag,
                         input int data, input logic spec);
    bus.i_fu_valid[s]                = v;
    bus.i_fu_tag_flatten[s*TW +: TW] = tag;
    bus.i_fu_wdata_flatten[s*DW +: DW] = data;
    bus.i_fu_speculation[s]          = spec;
  endtask

  task automatic clear_inputs();
    bus.i_fu_valid                  = '0;
    bus.i_fu_tag_flatten            = '0;
    bus.i_fu_wdata_flatten          = '0;
    bus.i_fu_speculation            = '0;
    bus.i_branch_valid              = 1'b0;
    bus.i_branch_correct_prediction = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (bus.o_cdb_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %0b expected 0", bus.o_cdb_valid);
    end
    checks++;
    if (bus.o_cdb_tag !== '0 || bus.o_cdb_wdata !== '0) begin
      errors++; $display("FAIL reset_bus: got tag=%0d data=%0d expected 0/0", bus.o_cdb_tag, bus.o_cdb_wdata);
    end
    checks++;
    if (bus.o_fu_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready_low: got %b expected 0000", bus.o_fu_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.o_fu_ready !== 4'b1111) begin
      errors++; $display("FAIL reset_ready_release: got %b expected 1111", bus.o_fu_ready);
    end
    step();
    checks++;
    if (bus.o_fu_ready !== 4'b1111 || bus.o_cdb_valid !== 1'b0) begin
      errors++; $display("FAIL reset_after: got ready=%b valid=%0b expected 1111/0", bus.o_fu_ready, bus.o_cdb_valid);
    end
  endtask

  task automatic test_single();
    set_src(1, 1'b1, 3'd3, -5, 1'b0);
    step();
    set_src(1, 1'b0, 3'd0, 0, 1'b0);
    checks++;
    if (bus.o_cdb_valid !== 1'b0) begin
      errors++; $display("FAIL single_early: got valid=%0b expected 0", bus.o_cdb_valid);
    end
    step();
    checks++;
    if ({bus.o_cdb_valid, bus.o_cdb_tag, bus.o_cdb_wdata} !== {1'b1, 3'd3, -32'sd5}) begin
      errors++; $display("FAIL single_bcast: got v=%0b tag=%0d data=%0d expected 1/3/-5",
                         bus.o_cdb_valid, bus.o_cdb_tag, bus.o_cdb_wdata);
    end
    step();
    checks++;
    if (bus.o_cdb_valid !== 1'b0) begin
      errors++; $display("FAIL single_after: got valid=%0b expected 0", bus.o_cdb_valid);
    end
  endtask

  task automatic test_contention();
    int exp_tag  [6] = '{1, 2, 3, 4, 3, 4};
    int exp_data [6] = '{11, 22, 33, 44, 303, 404};
    do_reset();
    for (int s = 0; s < NS; s++) set_src(s, 1'b1, TW'(s + 1), 11 * (s + 1), 1'b0);
    step();
    clear_inputs();
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        // pointer is back at 0: src2 and src3 push together
        set_src(2, 1'b1, 3'd3, 303, 1'b0);
        set_src(3, 1'b1, 3'd4, 404, 1'b0);
        step();
        clear_inputs();
      end
      step();
      checks++;
      if ({bus.o_cdb_valid, bus.o_cdb_tag, bus.o_cdb_wdata} !== {1'b1, TW'(exp_tag[k]), DW'(exp_data[k])}) begin
        errors++; $display("FAIL contention_%0d: got v=%0b tag=%0d data=%0d expected 1/%0d/%0d",
                           k, bus.o_cdb_valid, bus.o_cdb_tag, bus.o_cdb_wdata, exp_tag[k], exp_data[k]);
      end
    end
    step();
    checks++;
    if (bus.o_cdb_valid !== 1'b0) begin
      errors++; $display("FAIL contention_idle: got valid=%0b expected 0", bus.o_cdb_valid);
    end
  endtask

  task automatic test_full();
    int exp_tag  [3] = '{6, 2, 3};
    int exp_data [3] = '{60, 20, 30};
    // Park the pointer at 1 by broadcasting one src0 result
    set_src(0, 1'b1, 3'd7, 70, 1'b0);
    step();
    clear_inputs();
    step();
    checks++;
    if ({bus.o_cdb_valid, bus.o_cdb_tag} !== {1'b1, 3'd7}) begin
      errors++; $display("FAIL full_prime: got v=%0b tag=%0d expected 1/7", bus.o_cdb_valid, bus.o_cdb_tag);
    end
    step();
    set_src(0, 1'b1, 3'd1, 10, 1'b0);
    set_src(1, 1'b1, 3'd5, 50, 1'b0);
    step();
    set_src(0, 1'b1, 3'd2, 20, 1'b0);
    set_src(1, 1'b1, 3'd6, 60, 1'b0);
    step();
    checks++;
    if ({bus.o_cdb_valid, bus.o_cdb_tag, bus.o_cdb_wdata} !== {1'b1, 3'd5, 32'sd50}) begin
      errors++; $display("FAIL full_src1_first: got v=%0b tag=%0d data=%0d expected 1/5/50",
                         bus.o_cdb_valid, bus.o_cdb_tag, bus.o_cdb_wdata);
    end
    checks++;
    if (bus.o_fu_ready[0] !== 1'b0) begin
      errors++; $display("FAIL full_ready_low: got %0b expected 0", bus.o_fu_ready[0]);
    end
    set_src(0, 1'b1, 3'd3, 30, 1'b0);
    set_src(1, 1'b0, 3'd0, 0, 1'b0);
    step();
    checks++;
    if ({bus.o_cdb_valid, bus.o_cdb_tag, bus.o_cdb_wdata} !== {1'b1, 3'd1, 32'sd10}) begin
      errors++; $display("FAIL full_src0_head: got v=%0b tag=%0d data=%0d expected 1/1/10",
                         bus.o_cdb_valid, bus.o_cdb_tag, bus.o_cdb_wdata);
    end
    checks++;
    if (bus.o_fu_ready[0] !== 1'b1) begin
      errors++; $display("FAIL full_ready_back: got %0b expected 1", bus.o_fu_ready[0]);
    end
    step();
    clear_inputs();
    checks++;
    if (bus.o_fu_ready[0] !== 1'b0) begin
      errors++; $display("FAIL full_third_taken: got ready=%0b expected 0", bus.o_fu_ready[0]);
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      checks++;
      if ({bus.o_cdb_valid, bus.o_cdb_tag, bus.o_cdb_wdata} !== {1'b1, TW'(exp_tag[k]), DW'(exp_data[k])}) begin
        errors++; $display("FAIL full_order_%0d: got v=%0b tag=%0d data=%0d expected 1/%0d/%0d",
                           k, bus.o_cdb_valid, bus.o_cdb_tag, bus.o_cdb_wdata, exp_tag[k], exp_data[k]);
      end
    end
    step();
    checks++;
    if (bus.o_cdb_valid !== 1'b0) begin
      errors++; $display("FAIL full_idle: got valid=%0b expected 0", bus.o_cdb_valid);
    end
  endtask

  task automatic test_flush();
    // Pointer is at 1 on entry (last winner was src0)
    int exp_tag  [5] = '{1, 3, 2, 0, 0};
    int exp_data [5] = '{100, 300, 200, 0, 0};
    logic [TW+DW:0] exp;
    set_src(0, 1'b1, 3'd2, 200, 1'b0);
    set_src(1, 1'b1, 3'd1, 100, 1'b0);
    set_src(2, 1'b1, 3'd3, 300, 1'b0);
    step();
    clear_inputs();
    set_src(0, 1'b1, 3'd5, 500, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      clear_inputs();
      if (k == 0) begin
        bus.i_branch_valid = 1'b1;
        set_src(3, 1'b1, 3'd6, 600, 1'b1);
      end
      exp = (exp_tag[k] == 0) ? '0 : {1'b1, TW'(exp_tag[k]), DW'(exp_data[k])};
      checks++;
      if ({bus.o_cdb_valid, bus.o_cdb_tag, bus.o_cdb_wdata} !== exp) begin
        errors++; $display("FAIL flush_%0d: got v=%0b tag=%0d data=%0d expected tag=%0d data=%0d",
                           k, bus.o_cdb_valid, bus.o_cdb_tag, bus.o_cdb_wdata, exp_tag[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_commit();
    // Pointer is at 1 on entry (last winner was src0)
    int exp_tag  [7] = '{1, 2, 3, 4, 6, 5, 0};
    int exp_data [7] = '{11, 22, 33, 44, 66, 55, 0};
    logic [TW+DW:0] exp;
    set_src(0, 1'b1, 3'd4, 44, 1'b0);
    set_src(1, 1'b1, 3'd1, 11, 1'b0);
    set_src(2, 1'b1, 3'd2, 22, 1'b0);
    set_src(3, 1'b1, 3'd3, 33, 1'b0);
    step();
    clear_inputs();
    set_src(0, 1'b1, 3'd5, 55, 1'b1);
    for (int k = 0; k < 7; k++) begin
      step();
      clear_inputs();
      if (k == 0) begin
        bus.i_branch_valid = 1'b1;
        bus.i_branch_correct_prediction = 1'b1;
        set_src(1, 1'b1, 3'd6, 66, 1'b1);
      end else if (k == 1) begin
        bus.i_branch_valid = 1'b1;
      end
      exp = (exp_tag[k] == 0) ? '0 : {1'b1, TW'(exp_tag[k]), DW'(exp_data[k])};
      checks++;
      if ({bus.o_cdb_valid, bus.o_cdb_tag, bus.o_cdb_wdata} !== exp) begin
        errors++; $display("FAIL commit_%0d: got v=%0b tag=%0d data=%0d expected tag=%0d data=%0d",
                           k, bus.o_cdb_valid, bus.o_cdb_tag, bus.o_cdb_wdata, exp_tag[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_tag_zero();
    set_src(2, 1'b1, 3'd0, 999, 1'b0);
    step();
    clear_inputs();
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (bus.o_cdb_valid !== 1'b0) begin
        errors++; $display("FAIL tag_zero_%0d: got valid=%0b tag=%0d expected 0", k, bus.o_cdb_valid, bus.o_cdb_tag);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) set_src(0, 1'b1, TW'(k + 1), 7 * (k + 1), 1'b0);
      else clear_inputs();
      step();
      if (k >= 1 && k <= 4) begin
        checks++;
        if ({bus.o_cdb_valid, bus.o_cdb_tag, bus.o_cdb_wdata} !== {1'b1, TW'(k), DW'(7 * k)}) begin
          errors++; $display("FAIL b2b_%0d: got v=%0b tag=%0d data=%0d expected 1/%0d/%0d",
                             k, bus.o_cdb_valid, bus.o_cdb_tag, bus.o_cdb_wdata, k, 7 * k);
        end
        checks++;
        if (bus.o_fu_ready[0] !== 1'b1) begin
          errors++; $display("FAIL b2b_ready_%0d: got %0b expected 1", k, bus.o_fu_ready[0]);
        end
      end else if (k == 5) begin
        checks++;
        if (bus.o_cdb_valid !== 1'b0) begin
          errors++; $display("FAIL b2b_idle: got valid=%0b expected 0", bus.o_cdb_valid);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    set_src(0, 1'b1, 3'd1, 1, 1'b0);
    set_src(1, 1'b1, 3'd2, 2, 1'b0);
    step();
    clear_inputs();
    step();
    checks++;
    if (bus.o_cdb_valid !== 1'b1) begin
      errors++; $display("FAIL reset_mid_pre: got valid=%0b expected 1", bus.o_cdb_valid);
    end
    rst = 1'b1;
    step();
    checks++;
    if (bus.o_cdb_valid !== 1'b0 || bus.o_fu_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_mid_in: got valid=%0b ready=%b expected 0/0000", bus.o_cdb_valid, bus.o_fu_ready);
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (bus.o_cdb_valid !== 1'b0) begin
        errors++; $display("FAIL reset_mid_drop_%0d: got valid=%0b tag=%0d expected 0", k, bus.o_cdb_valid, bus.o_cdb_tag);
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_flush();
    test_commit();
    test_tag_zero();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
